// File: rtl/ptr_seq_pkg.sv
// ----------------------------------------------------------------------------
// ptr_seq_pkg
//   Shared definitions for pointer_sequencer: opcode width and encodings,
//   FSM state encoding, the registered strobe bank layout and the helper that
//   maps an FSM state onto the strobe values the pointer pair sees in that
//   state's cycle.
//   Optional feature macro: PTR_SEQ_DP_INC_EN (makes opcode 7 = MEM_DP_INC).
// ----------------------------------------------------------------------------
package ptr_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP      = 3'd0;
    localparam logic [OP_W-1:0] OP_FETCH    = 3'd1;
    localparam logic [OP_W-1:0] OP_LOAD_DP  = 3'd2;
    localparam logic [OP_W-1:0] OP_JUMP     = 3'd3;
    localparam logic [OP_W-1:0] OP_SWAP     = 3'd4;
    localparam logic [OP_W-1:0] OP_MEM_DP   = 3'd5;
    localparam logic [OP_W-1:0] OP_STORE_DP = 3'd6;
    localparam logic [OP_W-1:0] OP_DP_INC   = 3'd7;

    // One state per distinct op cycle. JUMP has its own load states because
    // its high-byte cycle continues into a swap instead of finishing.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_NOP  = 4'd1,   // single idle-like op cycle
        ST_F    = 4'd2,   // FETCH
        ST_LL   = 4'd3,   // LOAD_DP low byte
        ST_LH   = 4'd4,   // LOAD_DP high byte (final)
        ST_JLL  = 4'd5,   // JUMP low byte
        ST_JLH  = 4'd6,   // JUMP high byte
        ST_SW   = 4'd7,   // role swap (SWAP, tail of JUMP)
        ST_M    = 4'd8,   // MEM_DP
        ST_RL   = 4'd9,   // STORE_DP low byte
        ST_RH   = 4'd10,  // STORE_DP high byte
        ST_S1   = 4'd11,  // MEM_DP_INC: DP on address bus, then swap
        ST_C    = 4'd12,  // MEM_DP_INC: increment (old DP is IP now), swap back
        ST_S2   = 4'd13,  // MEM_DP_INC: finish
        ST_ERR  = 4'd14   // illegal op
    } state_t;

    // Registered strobe bank; strobes toward the pair are kept active-low so
    // the outputs come straight from flops.
    typedef struct packed {
        logic n_we_l;
        logic n_we_h;
        logic n_oe_addr_ip;
        logic n_oe_addr_dp;
        logic n_oe_dl;
        logic n_oe_dh;
        logic cnt;
        logic byte_sel;
        logic done;
        logic err;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{
        n_we_l:       1'b1,
        n_we_h:       1'b1,
        n_oe_addr_ip: 1'b1,
        n_oe_addr_dp: 1'b1,
        n_oe_dl:      1'b1,
        n_oe_dh:      1'b1,
        cnt:          1'b0,
        byte_sel:     1'b0,
        done:         1'b0,
        err:          1'b0
    };

    // Strobe values driven during the cycle spent in state s.
    function automatic strobe_t state_strobes(input state_t s);
        strobe_t o;
        o = STROBE_IDLE;
        case (s)
            ST_NOP: begin
                o.done = 1'b1;
            end
            ST_F: begin
                o.n_oe_addr_ip = 1'b0;
                o.cnt          = 1'b1;
                o.done         = 1'b1;
            end
            ST_LL, ST_JLL: begin
                o.n_we_l   = 1'b0;
                o.byte_sel = 1'b0;
            end
            ST_LH: begin
                o.n_we_h   = 1'b0;
                o.byte_sel = 1'b1;
                o.done     = 1'b1;
            end
            ST_JLH: begin
                o.n_we_h   = 1'b0;
                o.byte_sel = 1'b1;
            end
            ST_SW: begin
                o.done = 1'b1;
            end
            ST_M: begin
                o.n_oe_addr_dp = 1'b0;
                o.done         = 1'b1;
            end
            ST_RL: begin
                o.n_oe_dl  = 1'b0;
                o.byte_sel = 1'b0;
            end
            ST_RH: begin
                o.n_oe_dh  = 1'b0;
                o.byte_sel = 1'b1;
                o.done     = 1'b1;
            end
            ST_S1: begin
                o.n_oe_addr_dp = 1'b0;
            end
            ST_C: begin
                o.cnt = 1'b1;
            end
            ST_S2: begin
                o.done = 1'b1;
            end
            ST_ERR: begin
                o.err  = 1'b1;
                o.done = 1'b1;
            end
            default: begin
                o = STROBE_IDLE;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pointer_sequencer.sv
// ----------------------------------------------------------------------------
// pointer_sequencer
//   Control FSM for one IP/DP pointer pair. Takes one op at a time over a
//   valid/ready handshake and drives the pair's active-low strobes, its
//   increment enable and the IP/DP role selector. The selector lives here, so
//   a swap is one cycle and moves no data.
//
//   Optional feature macro: PTR_SEQ_DP_INC_EN
//     defined   : op 7 = MEM_DP_INC (DP on address bus, DP+1, roles unchanged)
//     undefined : op 7 is illegal -> one cycle with err and done
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   req_valid      in   op request valid
//   req_op         in   opcode, taken when req_valid & req_ready
//   req_ready      out  high only while idle (combinational from state)
//   done           out  pulse in the final cycle of an op
//   byte_sel       out  byte the pair moves this cycle (0 low, 1 high)
//   err            out  pulse when an illegal op is taken
//   n_we_l/n_we_h  out  DP low/high byte write, active low
//   n_oe_addr_ip   out  IP onto address bus, active low
//   n_oe_addr_dp   out  DP onto address bus, active low
//   n_oe_dl/n_oe_dh out DP low/high byte onto data bus, active low
//   cnt            out  IP increment enable
//   selector       out  IP/DP role swap
// ----------------------------------------------------------------------------
module pointer_sequencer
    import ptr_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [OP_W-1:0] req_op,
    output logic            req_ready,
    output logic            done,
    output logic            byte_sel,
    output logic            err,
    output logic            n_we_l,
    output logic            n_we_h,
    output logic            n_oe_addr_ip,
    output logic            n_oe_addr_dp,
    output logic            n_oe_dl,
    output logic            n_oe_dh,
    output logic            cnt,
    output logic            selector
);

    state_t  state_r;
    state_t  state_nx_s;
    strobe_t strb_r;
    strobe_t strb_nx_s;
    logic    sel_r;

    // Next-state logic: IDLE dispatches on the opcode, multi-cycle ops walk
    // their chain, every final state (and any unexpected code) returns to IDLE.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_NOP:      state_nx_s = ST_NOP;
                        OP_FETCH:    state_nx_s = ST_F;
                        OP_LOAD_DP:  state_nx_s = ST_LL;
                        OP_JUMP:     state_nx_s = ST_JLL;
                        OP_SWAP:     state_nx_s = ST_SW;
                        OP_MEM_DP:   state_nx_s = ST_M;
                        OP_STORE_DP: state_nx_s = ST_RL;
`ifdef PTR_SEQ_DP_INC_EN
                        OP_DP_INC:   state_nx_s = ST_S1;
`else
                        OP_DP_INC:   state_nx_s = ST_ERR;
`endif
                        default:     state_nx_s = ST_ERR;
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LL:   state_nx_s = ST_LH;
            ST_JLL:  state_nx_s = ST_JLH;
            ST_JLH:  state_nx_s = ST_SW;
            ST_RL:   state_nx_s = ST_RH;
            ST_S1:   state_nx_s = ST_C;
            ST_C:    state_nx_s = ST_S2;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered so that the flops
    // present them for exactly the cycle spent in that state.
    always_comb begin
        strb_nx_s = state_strobes(state_nx_s);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Output strobe bank; reset releases every strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_r <= STROBE_IDLE;
        end else begin
            strb_r <= strb_nx_s;
        end
    end

    // Role selector: flips on the edge that leaves a swap cycle. MEM_DP_INC
    // swaps twice so the increment hits the old DP while roles end unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r <= 1'b0;
        end else if ((state_r == ST_SW) || (state_r == ST_S1) || (state_r == ST_C)) begin
            sel_r <= ~sel_r;
        end else begin
            sel_r <= sel_r;
        end
    end

    assign req_ready    = (state_r == ST_IDLE);
    assign done         = strb_r.done;
    assign byte_sel     = strb_r.byte_sel;
    assign err          = strb_r.err;
    assign n_we_l       = strb_r.n_we_l;
    assign n_we_h       = strb_r.n_we_h;
    assign n_oe_addr_ip = strb_r.n_oe_addr_ip;
    assign n_oe_addr_dp = strb_r.n_oe_addr_dp;
    assign n_oe_dl      = strb_r.n_oe_dl;
    assign n_oe_dh      = strb_r.n_oe_dh;
    assign cnt          = strb_r.cnt;
    assign selector     = sel_r;

endmodule

// File: tb/tb_pointer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pointer_sequencer
//   Drives pointer_sequencer against a behavioural pointer pair (two 16-bit
//   registers whose IP/DP roles follow selector) and an op-level model of IP,
//   DP and selector. Honours PTR_SEQ_DP_INC_EN for opcode 7.
// ----------------------------------------------------------------------------
module tb_pointer_sequencer;
    import ptr_seq_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic [OP_W-1:0] req_op = 3'd0;
    logic            req_ready, done, byte_sel, err;
    logic            n_we_l, n_we_h, n_oe_addr_ip, n_oe_addr_dp, n_oe_dl, n_oe_dh;
    logic            cnt, selector;

    pointer_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .done(done), .byte_sel(byte_sel), .err(err),
        .n_we_l(n_we_l), .n_we_h(n_we_h), .n_oe_addr_ip(n_oe_addr_ip),
        .n_oe_addr_dp(n_oe_addr_dp), .n_oe_dl(n_oe_dl), .n_oe_dh(n_oe_dh),
        .cnt(cnt), .selector(selector)
    );

    always #1 clk = ~clk;

    // ---------------- behavioural pointer pair ----------------
    logic [15:0] pr0, pr1, p_ip, p_dp, nip, ndp, ld_data, addr_bus;
    logic [7:0]  din, data_bus;

    assign p_ip = selector ? pr1 : pr0;
    assign p_dp = selector ? pr0 : pr1;
    assign din  = byte_sel ? ld_data[15:8] : ld_data[7:0];
    assign addr_bus = !n_oe_addr_ip ? p_ip : (!n_oe_addr_dp ? p_dp : 16'h0000);
    assign data_bus = !n_oe_dl ? p_dp[7:0] : (!n_oe_dh ? p_dp[15:8] : 8'h00);

    always_comb begin
        nip = p_ip + {15'd0, cnt};
        ndp = p_dp;
        if (!n_we_l) ndp[7:0]  = din;
        if (!n_we_h) ndp[15:8] = din;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pr0 <= 16'h0000;
            pr1 <= 16'h0000;
        end else if (selector) begin
            pr1 <= nip;
            pr0 <= ndp;
        end else begin
            pr0 <= nip;
            pr1 <= ndp;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Asserted (active-high) view of everything the sequencer drives except selector.
    logic [9:0] act_vec;
    assign act_vec = {~n_we_l, ~n_we_h, ~n_oe_addr_ip, ~n_oe_addr_dp, ~n_oe_dl, ~n_oe_dh,
                      cnt, byte_sel, done, err};

    typedef struct packed {
        logic we_l; logic we_h; logic oe_ip; logic oe_dp; logic oe_dl; logic oe_dh;
        logic cnt;  logic bsel; logic done;  logic err;  logic tog;
    } cyc_t;

    function automatic int op_len(input logic [2:0] op);
        case (op)
            3'd2, 3'd6: return 2;
            3'd3:       return 3;
`ifdef PTR_SEQ_DP_INC_EN
            3'd7:       return 3;
`endif
            default:    return 1;
        endcase
    endfunction

    // Per-cycle behaviour of each op; tog marks a selector flip at cycle end.
    function automatic cyc_t cyc_exp(input logic [2:0] op, input int k);
        cyc_t e;
        e = '0;
        case (op)
            3'd0: e.done = 1'b1;
            3'd1: begin e.oe_ip = 1'b1; e.cnt = 1'b1; e.done = 1'b1; end
            3'd2: if (k == 0) e.we_l = 1'b1;
                  else begin e.we_h = 1'b1; e.bsel = 1'b1; e.done = 1'b1; end
            3'd3: if (k == 0) e.we_l = 1'b1;
                  else if (k == 1) begin e.we_h = 1'b1; e.bsel = 1'b1; end
                  else begin e.done = 1'b1; e.tog = 1'b1; end
            3'd4: begin e.done = 1'b1; e.tog = 1'b1; end
            3'd5: begin e.oe_dp = 1'b1; e.done = 1'b1; end
            3'd6: if (k == 0) e.oe_dl = 1'b1;
                  else begin e.oe_dh = 1'b1; e.bsel = 1'b1; e.done = 1'b1; end
`ifdef PTR_SEQ_DP_INC_EN
            3'd7: if (k == 0) begin e.oe_dp = 1'b1; e.tog = 1'b1; end
                  else if (k == 1) begin e.cnt = 1'b1; e.tog = 1'b1; end
                  else e.done = 1'b1;
`else
            3'd7: begin e.done = 1'b1; e.err = 1'b1; end
`endif
            default: e = '0;
        endcase
        return e;
    endfunction

    // ---------------- op-level reference state ----------------
    logic [15:0] m_ip = 16'h0000, m_dp = 16'h0000;
    logic        m_sel = 1'b0;
    logic [15:0] cap_addr;
    logic [7:0]  cap_dlo, cap_dhi;

    // Issue one op at a negedge while idle, check every cycle and the idle cycle after.
    task automatic do_op(input logic [2:0] op, input logic [15:0] d);
        int   w;
        cyc_t e;
        logic [9:0] ev;
        w = 0;
        while (req_ready !== 1'b1 && w < 16) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        cap_addr  = 16'hxxxx;
        cap_dlo   = 8'hxx;
        cap_dhi   = 8'hxx;
        ld_data   = d;
        req_op    = op;
        req_valid = 1'b1;
        for (int k = 0; k < op_len(op); k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            e  = cyc_exp(op, k);
            ev = {e.we_l, e.we_h, e.oe_ip, e.oe_dp, e.oe_dl, e.oe_dh, e.cnt, e.bsel, e.done, e.err};
            chk("strobes", {22'd0, act_vec}, {22'd0, ev});
            chk("selector", {31'd0, selector}, {31'd0, m_sel});
            chk("busy_ready", {31'd0, req_ready}, 32'd0);
            chk("addr_oe_excl", {31'd0, (!n_oe_addr_ip && !n_oe_addr_dp)}, 32'd0);
            if (!n_oe_addr_ip || !n_oe_addr_dp) cap_addr = addr_bus;
            if (!n_oe_dl) cap_dlo = data_bus;
            if (!n_oe_dh) cap_dhi = data_bus;
            if (e.tog) m_sel = ~m_sel;
        end
        case (op)
            3'd1: begin chk("fetch_addr", {16'd0, cap_addr}, {16'd0, m_ip}); m_ip = m_ip + 16'd1; end
            3'd2: m_dp = d;
            3'd3: begin m_dp = m_ip; m_ip = d; end
            3'd4: begin m_dp = m_ip; m_ip = p_dp_swap_src(m_dp, m_ip); end
            3'd5: chk("mem_addr", {16'd0, cap_addr}, {16'd0, m_dp});
            3'd6: chk("store_data", {16'd0, cap_dhi, cap_dlo}, {16'd0, m_dp});
`ifdef PTR_SEQ_DP_INC_EN
            3'd7: begin chk("dpinc_addr", {16'd0, cap_addr}, {16'd0, m_dp}); m_dp = m_dp + 16'd1; end
`endif
            default: ;
        endcase
        @(negedge clk);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_strobes", {22'd0, act_vec}, 32'd0);
        chk("sel_after", {31'd0, selector}, {31'd0, m_sel});
        chk("pair_ip", {16'd0, p_ip}, {16'd0, m_ip});
        chk("pair_dp", {16'd0, p_dp}, {16'd0, m_dp});
    endtask

    logic [15:0] swap_tmp;
    // SWAP helper: m_dp has already taken the old IP; return the saved old DP.
    function automatic logic [15:0] p_dp_swap_src(input logic [15:0] new_dp, input logic [15:0] old_ip);
        return swap_tmp;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  op;
        logic [15:0] d;
        logic        exp_sel;
        logic        chk_addr;
        logic [15:0] exp_addr;
        logic        chk_data;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{OP_LOAD_DP,  16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{OP_MEM_DP,   16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000};
        vecs[2]  = '{OP_STORE_DP, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234};
        vecs[3]  = '{OP_JUMP,     16'hFFFE, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[4]  = '{OP_FETCH,    16'h0000, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0000};
        vecs[5]  = '{OP_FETCH,    16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000};
        vecs[6]  = '{OP_FETCH,    16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[7]  = '{OP_SWAP,     16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[8]  = '{OP_MEM_DP,   16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
        vecs[9]  = '{OP_SWAP,     16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{OP_FETCH,    16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000};
        vecs[11] = '{OP_LOAD_DP,  16'h00FF, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
`ifdef PTR_SEQ_DP_INC_EN
        vecs[12] = '{OP_DP_INC,   16'h0000, 1'b1, 1'b1, 16'h00FF, 1'b0, 16'h0000};
        vecs[13] = '{OP_MEM_DP,   16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000};
`else
        vecs[12] = '{OP_DP_INC,   16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[13] = '{OP_MEM_DP,   16'h0000, 1'b1, 1'b1, 16'h00FF, 1'b0, 16'h0000};
`endif
        ld_data  = 16'h0000;
        swap_tmp = 16'h0000;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {22'd0, act_vec}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_selector", {31'd0, selector}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_strobes", {22'd0, act_vec}, 32'd0);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // directed table
        for (int i = 0; i < 14; i++) begin
            swap_tmp = m_dp;
            do_op(vecs[i].op, vecs[i].d);
            chk("tab_sel", {31'd0, selector}, {31'd0, vecs[i].exp_sel});
            if (vecs[i].chk_addr) chk("tab_addr", {16'd0, cap_addr}, {16'd0, vecs[i].exp_addr});
            if (vecs[i].chk_data) chk("tab_data", {16'd0, cap_dhi, cap_dlo}, {16'd0, vecs[i].exp_data});
        end

        // request held while LOAD_DP is busy; next op taken in the IDLE cycle
        ld_data   = 16'hABCD;
        req_op    = OP_LOAD_DP;
        req_valid = 1'b1;
        @(negedge clk);
        req_op = OP_MEM_DP;
        chk("hold_ready0", {31'd0, req_ready}, 32'd0);
        chk("hold_we_l", {31'd0, n_we_l}, 32'd0);
        @(negedge clk);
        chk("hold_ready1", {31'd0, req_ready}, 32'd0);
        chk("hold_we_h", {31'd0, n_we_h}, 32'd0);
        chk("hold_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("hold_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("hold_idle_strobes", {22'd0, act_vec}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold_mem_oe", {30'd0, n_oe_addr_ip, n_oe_addr_dp}, 32'd2);
        chk("hold_mem_addr", {16'd0, addr_bus}, 32'h0000ABCD);
        chk("hold_mem_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("hold_end_ready", {31'd0, req_ready}, 32'd1);
        m_dp = 16'hABCD;

        // reset in the middle of LOAD_DP aborts at once
        ld_data   = 16'h5678;
        req_op    = OP_LOAD_DP;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_we_l", {31'd0, n_we_l}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strobes", {22'd0, act_vec}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_selector", {31'd0, selector}, 32'd0);
        rst   = 1'b0;
        m_ip  = 16'h0000;
        m_dp  = 16'h0000;
        m_sel = 1'b0;
        @(negedge clk);
        chk("abort_idle_strobes", {22'd0, act_vec}, 32'd0);
        chk("abort_pair_dp", {16'd0, p_dp}, 32'd0);

        // randomized ops with random idle gaps
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("gap_idle", {22'd0, act_vec}, 32'd0);
            end
            swap_tmp = m_dp;
            do_op(3'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
